// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and serializes them as start/data/parity/stop frames
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic                  parity, parity_n;
    logic                  tx_n, done_n, bit_end;

    assign busy = state != IDLE;

    // Next-state logic; tx and frame_done are derived from the next state so their registers line up with it
    always_comb begin
        state_n  = state;
        shift_n  = shift;
        idx_n    = idx;
        parity_n = parity;
        read_en  = 1'b0;
        bit_end  = cnt == CNT_LAST;
        cnt_n    = (state == IDLE || state == LOAD || bit_end) ? '0 : cnt + 1'b1;
        case (state)
            IDLE: begin
                read_en = reset_n & tx_enable & ~fifo_empty;
                state_n = read_en ? LOAD : IDLE;
            end
            LOAD: begin
                shift_n  = fifo_data;
                parity_n = ^fifo_data;
                idx_n    = '0;
                state_n  = START;
            end
            START:  state_n = bit_end ? DATA : START;
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    idx_n   = idx + 1'b1;
                    if (idx == IDX_LAST) state_n = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: state_n = bit_end ? STOP : PARITY;
            STOP:   state_n = bit_end ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
        tx_n   = state_n == START  ? 1'b0 :
                 state_n == DATA   ? shift_n[0] :
                 state_n == PARITY ? parity_n : 1'b1;
        done_n = state_n == STOP && cnt_n == CNT_LAST;
    end

    // State and datapath registers with synchronous active-low reset; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= '0;
            cnt        <= '0;
            idx        <= '0;
            parity     <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            parity     <= parity_n;
            tx         <= tx_n;
            frame_done <= done_n;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; a line monitor decodes frames and checks them against queued expectations
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n, en, sel, wr;
    logic [7:0] wd;
    logic       fe = 1'b1;
    logic [7:0] fd = 8'h00;
    logic       en0, en1, re0, re1, tx0, tx1, busy0, busy1, done0, done1;
    logic       txm, fdm;
    logic [7:0] fq[$];
    exp_t       sb[$];
    int         cyc = 0, re_cnt = 0, last_re = -100;
    int         frames = 0, last_done = -1000;
    int         total = 0, passed = 0;

    always #5 clk = ~clk;

    assign en0 = en & ~sel;
    assign en1 = en & sel;
    assign txm = sel ? tx1 : tx0;
    assign fdm = sel ? done1 : done0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .tx_enable(en0), .fifo_empty(fe), .fifo_data(fd),
        .read_en(re0), .tx(tx0), .busy(busy0), .frame_done(done0)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .tx_enable(en1), .fifo_empty(fe), .fifo_data(fd),
        .read_en(re1), .tx(tx1), .busy(busy1), .frame_done(done1)
    );

    // FIFO model: data_out valid the cycle after a pop
    always @(posedge clk) begin
        if ((re0 | re1) && fq.size() > 0) fd <= fq.pop_front();
        if (wr) fq.push_back(wd);
        fe <= (fq.size() == 0);
    end

    // Cycle counter and pop bookkeeping
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re0 | re1) begin
            re_cnt  <= re_cnt + 1;
            last_re <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [7:0] d);
        wr = 1'b1;
        wd = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic expect_word(input logic [7:0] d, input int g);
        exp_t e;
        e.data = d;
        e.gap  = g;
        sb.push_back(e);
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames < n && t < 3000) begin
            tick();
            t++;
        end
        chk("frame_arrival", frames >= n, 1);
    endtask

    // Line monitor: decodes each frame from the selected DUT and scores it
    initial begin
        int         start, nb, done_at, done_cyc;
        logic [10:0] bits;
        logic       glitch, aborted;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1 || txm !== 1'b0) continue;
            start = cyc;
            nb = sel ? 11 : 10;
            done_at = 0;
            done_cyc = 0;
            bits = '0;
            glitch = 1'b0;
            aborted = 1'b0;
            for (int b = 0; b < nb && !aborted; b++) begin
                for (int c = 0; c < CPB && !aborted; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (reset_n !== 1'b1) aborted = 1'b1;
                    else begin
                        if (c == 0) bits[b] = txm;
                        else if (txm !== bits[b]) glitch = 1'b1;
                        if (fdm === 1'b1 && done_at == 0) begin
                            done_at = b * CPB + c + 1;
                            done_cyc = cyc;
                        end
                    end
                end
            end
            if (aborted) continue;
            chk("frame_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data", bits[8:1], e.data);
                if (sel) chk("parity", bits[9], ^e.data);
                chk("start_bit", bits[0], 0);
                chk("stop_bit", bits[nb-1], 1);
                chk("bit_glitch", glitch, 0);
                chk("frame_done_cycle", done_at, nb * CPB);
                chk("pop_to_start", start - last_re, 2);
                if (e.gap >= 0) chk("line_high_gap", start - last_done - 1 + CPB, e.gap);
            end
            last_done = done_cyc;
            frames++;
        end
    end

    // Directed stimulus
    initial begin
        int r, bad;
        reset_n = 1'b0;
        en = 1'b0;
        sel = 1'b0;
        wr = 1'b0;
        wd = 8'h00;
        tick();
        tick();
        expect_word(8'hA5, -1);
        fifo_write(8'hA5);
        en = 1'b1;
        tick();
        chk("read_en_in_reset", re0, 0);
        tick();
        chk("read_en_in_reset", re0, 0);
        chk("reset_tx0", tx0, 1);
        chk("reset_busy0", busy0, 0);
        chk("reset_done0", done0, 0);
        chk("reset_tx1", tx1, 1);
        chk("reset_busy1", busy1, 0);
        reset_n = 1'b1;
        wait_frames(1);
        repeat (4) tick();
        chk("single_pop_count", re_cnt, 1);
        chk("idle_after_single", busy0, 0);
        chk("tx_idle_high", tx0, 1);

        en = 1'b0;
        fifo_write(8'h11);
        fifo_write(8'h22);
        fifo_write(8'h33);
        expect_word(8'h11, -1);
        expect_word(8'h22, CPB + 2);
        expect_word(8'h33, CPB + 2);
        en = 1'b1;
        wait_frames(4);
        repeat (4) tick();
        chk("burst_fifo_empty", fe, 1);
        chk("burst_idle", busy0, 0);
        chk("burst_pop_count", re_cnt, 4);

        en = 1'b0;
        fifo_write(8'h5A);
        fifo_write(8'h77);
        expect_word(8'h5A, -1);
        r = re_cnt;
        en = 1'b1;
        repeat (15) tick();
        chk("busy_mid_frame", busy0, 1);
        en = 1'b0;
        wait_frames(5);
        repeat (20) tick();
        chk("no_pop_while_disabled", re_cnt, r + 1);
        chk("fifo_holds_one", fq.size(), 1);
        chk("fifo_head", (fq.size() == 1) ? fq[0] : 8'h00, 8'h77);
        expect_word(8'h77, -1);
        en = 1'b1;
        wait_frames(6);

        en = 1'b0;
        repeat (4) tick();
        fifo_write(8'h3C);
        fifo_write(8'h96);
        expect_word(8'h96, -1);
        r = re_cnt;
        en = 1'b1;
        repeat (15) tick();
        chk("busy_before_reset", busy0, 1);
        reset_n = 1'b0;
        #1;
        chk("read_en_in_reset_mid", re0, 0);
        tick();
        reset_n = 1'b1;
        chk("tx_after_reset", tx0, 1);
        chk("busy_after_reset", busy0, 0);
        wait_frames(7);
        repeat (4) tick();
        chk("reset_pop_count", re_cnt, r + 2);

        en = 1'b0;
        repeat (4) tick();
        sel = 1'b1;
        fifo_write(8'h01);
        fifo_write(8'h03);
        expect_word(8'h01, -1);
        expect_word(8'h03, CPB + 2);
        en = 1'b1;
        wait_frames(9);
        repeat (4) tick();
        chk("parity_idle", busy1, 0);

        en = 1'b0;
        tick();
        sel = 1'b0;
        en = 1'b1;
        bad = 0;
        repeat (100) begin
            tick();
            if (re0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        chk("empty_fifo_quiet", bad, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
